// File: rtl/ber_pattern_tx.sv
// ber_pattern_tx: BER link transmitter, alternating 1010 stream with preamble, payload, constant-0 tail and single-bit error injection.
// Ports:
//   clk9MHz, rst_n (async, active-low)
//   cmd_valid/cmd_data/cmd_ready : command byte (5A START, A5 ABORT)
//   inject_err                   : invert the next payload bit
//   tx_bit_data                  : registered serial line
//   tx_busy, tx_done             : run active, one-clock completion pulse
//   bits_sent, err_injected      : payload bits sent / inverted in the current run
module ber_pattern_tx #(
  parameter int unsigned BIT_DIV       = 1,
  parameter int unsigned PREAMBLE_BITS = 32,
  parameter int unsigned PAYLOAD_BITS  = 80000000,
  parameter int unsigned TAIL_BITS     = 256
) (
  input  logic        clk9MHz,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ready,
  input  logic        inject_err,
  output logic        tx_bit_data,
  output logic        tx_busy,
  output logic        tx_done,
  output logic [31:0] bits_sent,
  output logic [15:0] err_injected
);
  localparam int DW = BIT_DIV > 1 ? $clog2(BIT_DIV) : 1;
  localparam int PW = PREAMBLE_BITS > 1 ? $clog2(PREAMBLE_BITS) : 1;
  localparam int TW = TAIL_BITS > 1 ? $clog2(TAIL_BITS) : 1;
  localparam logic [1:0] IDLE = 2'd0, PRE = 2'd1, PAY = 2'd2, TAIL = 2'd3;
  logic [1:0] state;
  logic [DW-1:0] div;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic ph, pend;
  logic acc, start, abort, end_p, inv;
  assign acc     = cmd_valid && cmd_ready;
  assign start   = acc && cmd_data == 8'h5A;
  assign abort   = acc && cmd_data == 8'hA5;
  assign end_p   = div == DW'(BIT_DIV - 1);
  // a request seen on the very clock a bit ends still targets the bit that starts next
  assign inv     = pend || inject_err;
  assign tx_busy = state != IDLE;
  // ph is the reference alternation value of the bit on the line, independent of any inversion
  always_ff @(posedge clk9MHz or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      div          <= '0;
      pcnt         <= '0;
      tcnt         <= '0;
      ph           <= 1'b0;
      pend         <= 1'b0;
      cmd_ready    <= 1'b1;
      tx_bit_data  <= 1'b0;
      tx_done      <= 1'b0;
      bits_sent    <= '0;
      err_injected <= '0;
    end else begin
      cmd_ready <= !acc;
      tx_done   <= 1'b0;
      if (state == IDLE) begin
        div <= '0;
        if (start) begin
          state        <= PRE;
          tx_bit_data  <= 1'b1;
          ph           <= 1'b1;
          pcnt         <= '0;
          tcnt         <= '0;
          pend         <= 1'b0;
          bits_sent    <= '0;
          err_injected <= '0;
        end
      end else if (abort) begin
        state       <= IDLE;
        tx_bit_data <= 1'b0;
        pend        <= 1'b0;
        div         <= '0;
      end else begin
        div <= end_p ? '0 : div + 1'b1;
        if (state == PRE && end_p) begin
          ph          <= ~ph;
          tx_bit_data <= ~ph;
          pcnt        <= pcnt + 1'b1;
          if (pcnt == PW'(PREAMBLE_BITS - 1)) state <= PAY;
        end else if (state == PAY) begin
          pend <= end_p ? 1'b0 : inv;
          if (end_p) begin
            bits_sent <= bits_sent + 1'b1;
            if (bits_sent == 32'(PAYLOAD_BITS - 1)) begin
              state       <= TAIL;
              tx_bit_data <= 1'b0;
            end else begin
              ph          <= ~ph;
              tx_bit_data <= ~ph ^ inv;
              if (inv && err_injected != 16'hFFFF) err_injected <= err_injected + 1'b1;
            end
          end
        end else if (state == TAIL && end_p) begin
          tcnt <= tcnt + 1'b1;
          if (tcnt == TW'(TAIL_BITS - 1)) begin
            state   <= IDLE;
            tx_done <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ber_pattern_tx.sv
// tb_ber_pattern_tx: scoreboard bench for ber_pattern_tx at BIT_DIV=1 (dut a) and BIT_DIV=3 (dut b).
module tb_ber_pattern_tx;
  localparam int PRE = 16, PAY = 64, TL = 8;
  logic clk9MHz = 1'b0;
  logic rst_n = 1'b0;
  logic a_valid = 1'b0, b_valid = 1'b0, a_inj = 1'b0, b_inj = 1'b0;
  logic [7:0] a_data = '0, b_data = '0;
  logic a_ready, a_tx, a_busy, a_done, b_ready, b_tx, b_busy, b_done;
  logic [31:0] a_bits, b_bits;
  logic [15:0] a_err, b_err;
  typedef struct packed {logic tx; logic busy; logic done;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;

  always #5 clk9MHz = ~clk9MHz;

  ber_pattern_tx #(.BIT_DIV(1), .PREAMBLE_BITS(PRE), .PAYLOAD_BITS(PAY), .TAIL_BITS(TL)) dut_a (
    .clk9MHz(clk9MHz), .rst_n(rst_n), .cmd_valid(a_valid), .cmd_data(a_data), .cmd_ready(a_ready),
    .inject_err(a_inj), .tx_bit_data(a_tx), .tx_busy(a_busy), .tx_done(a_done),
    .bits_sent(a_bits), .err_injected(a_err));

  ber_pattern_tx #(.BIT_DIV(3), .PREAMBLE_BITS(PRE), .PAYLOAD_BITS(PAY), .TAIL_BITS(TL)) dut_b (
    .clk9MHz(clk9MHz), .rst_n(rst_n), .cmd_valid(b_valid), .cmd_data(b_data), .cmd_ready(b_ready),
    .inject_err(b_inj), .tx_bit_data(b_tx), .tx_busy(b_busy), .tx_done(b_done),
    .bits_sent(b_bits), .err_injected(b_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected line/busy/done for every clock of a run, from clock 1 to two clocks past the last tail bit
  task automatic push_run(input int d, input int i1, input int i2);
    int n, p, k;
    exp_t e;
    n = (PRE + PAY + TL) * d;
    for (int c = 1; c <= n + 2; c++) begin
      p = (c - 1) / d;
      k = p - PRE + 1;
      if (c > n) begin
        e.tx = 1'b0; e.busy = 1'b0; e.done = (c == n + 1);
      end else if (p < PRE + PAY) begin
        e.tx = ((p % 2) == 0) ^ (p >= PRE && (k == i1 || k == i2)); e.busy = 1'b1; e.done = 1'b0;
      end else begin
        e.tx = 1'b0; e.busy = 1'b1; e.done = 1'b0;
      end
      q.push_back(e);
    end
  endtask

  // entered at the negedge of clock 1; ia/ib/ic are clocks on which inject_err is held high,
  // cmd_at is a clock on which a START byte is offered to dut a
  task automatic drain(input bit sel_b, input int n, input int ia, input int ib, input int ic, input int cmd_at);
    int samples;
    logic [15:0] sh;
    exp_t e;
    logic t, bz, dn, rdy;
    samples = 0;
    sh = '0;
    for (int c = 1; c <= n; c++) begin
      if (c > 1) @(negedge clk9MHz);
      e = q.pop_front();
      t = sel_b ? b_tx : a_tx;
      bz = sel_b ? b_busy : a_busy;
      dn = sel_b ? b_done : a_done;
      rdy = sel_b ? b_ready : a_ready;
      chk($sformatf("tx c%0d", c), 32'(t), 32'(e.tx));
      chk($sformatf("busy c%0d", c), 32'(bz), 32'(e.busy));
      chk($sformatf("done c%0d", c), 32'(dn), 32'(e.done));
      if (c == 2) chk("ready_back", 32'(rdy), 32'd1);
      if (cmd_at > 0 && c == cmd_at + 1) chk("ready_after_2nd", 32'(rdy), 32'd0);
      if (sel_b && (c % 3) == 1) begin
        sh = {sh[14:0], t};
        samples++;
        if (samples == 16) chk("sniff_aaaa", 32'(sh), 32'h0000AAAA);
        if (samples == 17) chk("sniff_5555", 32'(sh), 32'h00005555);
      end
      if (sel_b) b_inj = (c == ia || c == ib || c == ic);
      else a_inj = (c == ia || c == ib || c == ic);
      a_valid = !sel_b && c == cmd_at;
      a_data = 8'h5A;
    end
    a_inj = 1'b0;
    b_inj = 1'b0;
    a_valid = 1'b0;
  endtask

  // called at a negedge; returns at the negedge of the clock after acceptance
  task automatic send(input bit sel_b, input logic [7:0] byt);
    chk("ready_before", 32'(sel_b ? b_ready : a_ready), 32'd1);
    if (sel_b) begin b_valid = 1'b1; b_data = byt; end
    else begin a_valid = 1'b1; a_data = byt; end
    @(negedge clk9MHz);
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk("ready_drop", 32'(sel_b ? b_ready : a_ready), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk9MHz);
    rst_n = 1'b1;
    @(negedge clk9MHz);
    chk("rst_tx", 32'(a_tx), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_bits", a_bits, 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    // basic run, one clock per bit
    send(0, 8'h5A);
    push_run(1, 999, 999);
    drain(0, 90, 0, 0, 0, 0);
    chk("basic_bits", a_bits, 32'd64);
    chk("basic_err", 32'(a_err), 32'd0);
    // three clocks per bit, with decimated sniffer
    send(1, 8'h5A);
    push_run(3, 999, 999);
    drain(1, 266, 0, 0, 0, 0);
    chk("div3_bits", b_bits, 32'd64);
    chk("div3_err", 32'(b_err), 32'd0);
    // injection: once inside payload bit 10, twice inside payload bit 20 (last one on its final clock)
    send(1, 8'h5A);
    push_run(3, 11, 21);
    drain(1, 266, 77, 106, 108, 0);
    chk("inj_err", 32'(b_err), 32'd2);
    chk("inj_bits", b_bits, 32'd64);
    // abort mid-payload: accepted on clock 40, payload periods ended on clocks 17..39
    send(0, 8'h5A);
    push_run(1, 999, 999);
    drain(0, 40, 0, 0, 0, 0);
    q.delete();
    send(0, 8'hA5);
    chk("abort_busy", 32'(a_busy), 32'd0);
    chk("abort_tx", 32'(a_tx), 32'd0);
    chk("abort_done", 32'(a_done), 32'd0);
    chk("abort_bits", a_bits, 32'd23);
    repeat (3) begin
      @(negedge clk9MHz);
      chk("abort_no_done", 32'(a_done), 32'd0);
      chk("abort_bits_hold", a_bits, 32'd23);
    end
    // restart after abort
    send(0, 8'h5A);
    chk("restart_bits_clr", a_bits, 32'd0);
    push_run(1, 999, 999);
    drain(0, 90, 0, 0, 0, 0);
    chk("restart_bits", a_bits, 32'd64);
    // second START on clock 2 while busy must be ignored
    send(0, 8'h5A);
    push_run(1, 999, 999);
    drain(0, 90, 0, 0, 0, 2);
    chk("b2b_bits", a_bits, 32'd64);
    // ABORT while idle changes nothing
    send(0, 8'hA5);
    chk("idle_abort_busy", 32'(a_busy), 32'd0);
    chk("idle_abort_bits", a_bits, 32'd64);
    @(negedge clk9MHz);
    // asynchronous reset inside the tail (clocks 81..88)
    send(0, 8'h5A);
    push_run(1, 999, 999);
    drain(0, 84, 0, 0, 0, 0);
    q.delete();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", 32'(a_tx), 32'd0);
    chk("arst_busy", 32'(a_busy), 32'd0);
    chk("arst_done", 32'(a_done), 32'd0);
    chk("arst_ready", 32'(a_ready), 32'd1);
    chk("arst_bits", a_bits, 32'd0);
    chk("arst_err", 32'(a_err), 32'd0);
    @(negedge clk9MHz);
    chk("arst_hold_done", 32'(a_done), 32'd0);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk9MHz);
      chk("arst_no_done", 32'(a_done), 32'd0);
      chk("arst_idle", 32'(a_busy), 32'd0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ber_pattern_tx.md
Name: ber_pattern_tx

Overview:
- Transmit end of the BA1533 bit-error-rate link.
- On a start command from the UART/MCU path, emits a continuous alternating 1010… bit stream on a single line, clocked out at a fixed bit rate:
  - a preamble, so the far-end receiver can lock onto the AAAA/5555 pattern;
  - a fixed-length payload;
  - a constant-level tail, so the far end's no-change end detector fires.
- Supports single-bit error injection, so the far-end pass percentage can be checked against a known error count.

Parameters:
- BIT_DIV, 1: clocks per transmitted bit (≥1).
- PREAMBLE_BITS, 32: alternating bits before payload (even, ≥16).
- PAYLOAD_BITS, 80000000: payload bits. Matches far-end max_rx_count 32'h4C4B400.
- TAIL_BITS, 256: bit periods of constant 0 after payload. ≥201 in product; tests may override.

Ports:
- clk9MHz  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command byte valid.
- cmd_data  in  8  command byte: 8'h5A = START, 8'hA5 = ABORT, others ignored.
- cmd_ready  out  1  command accept; byte consumed when cmd_valid && cmd_ready.
- inject_err  in  1  request to invert the next payload bit.
- tx_bit_data  out  1  serial line to the link (registered).
- tx_busy  out  1  high in PREAMBLE/PAYLOAD/TAIL.
- tx_done  out  1  one-clock pulse on normal completion.
- bits_sent  out  32  payload bits completed in the current run.
- err_injected  out  16  payload bits inverted in the current run (saturating).

Behaviour:
- Reset: one clock, clk9MHz. rst_n is asynchronous, active-low.
  - Outputs: tx_bit_data=0, tx_busy=0, tx_done=0, cmd_ready=1, bits_sent=0, err_injected=0.
  - Internal: state=IDLE, bit divider=0.
  - Reset mid-run aborts immediately with these values.
- States: IDLE → PREAMBLE → PAYLOAD → TAIL → IDLE.
- cmd_ready:
  - Drops for exactly the clock after any accepted byte, then returns to 1.
  - Max one command per 2 clocks.
- Bit strobe:
  - Divider runs 0..BIT_DIV-1 in active states, cleared in IDLE.
  - A bit period ends when the divider reaches BIT_DIV-1.
  - tx_bit_data changes only on the clock after a period end, or on entry/exit of a run.
- START in IDLE (accepted at clock N):
  - At N+1: state=PREAMBLE, tx_bit_data=1, tx_busy=1.
  - bits_sent and err_injected cleared; divider cleared.
  - START while active is ignored, but the byte is still consumed.
- PREAMBLE: PREAMBLE_BITS periods alternating 1,0,1,0…
- PAYLOAD:
  - Continues the alternation with no phase break: the first payload bit is 1, because PREAMBLE_BITS is even.
  - bits_sent increments at each payload period end.
  - After PAYLOAD_BITS periods (bits_sent == PAYLOAD_BITS), go to TAIL.
- Error injection:
  - inject_err is sampled high on any clock in PAYLOAD; the next payload bit to start is driven inverted.
  - Only that single bit is inverted. The reference alternation phase advances as if not inverted.
  - Multiple requests before that bit starts coalesce into one.
  - err_injected increments when the inverted bit starts and saturates at 16'hFFFF.
  - A request pending at payload end is dropped.
  - inject_err is ignored outside PAYLOAD.
- TAIL:
  - tx_bit_data=0 for TAIL_BITS periods.
  - Then, on the next clock: tx_done=1 for one clock, tx_busy=0, state=IDLE, tx_bit_data=0.
- ABORT accepted while active:
  - Next clock: state=IDLE, tx_busy=0, tx_bit_data=0, no tx_done.
  - bits_sent and err_injected hold their values.
  - ABORT in IDLE: no effect.
- Priority: rst_n > ABORT > normal sequencing/inject_err.
- bits_sent and err_injected hold after completion until the next START.
- Arithmetic:
  - Internal bit counter is 32 bits; no wrap for the default parameters.
  - Preamble/tail counters sized by $clog2.

Test Plan:
- Basic run, BIT_DIV=1, PREAMBLE_BITS=16, PAYLOAD_BITS=64, TAIL_BITS=8; START accepted at clock 0:
  - clocks 1–80 tx_bit_data = 1,0,1,0… ;
  - clocks 81–88 = 0;
  - tx_done=1 only at clock 89; tx_busy high clocks 1–88;
  - bits_sent=64, err_injected=0.
- BIT_DIV=3, same other parameters:
  - each bit held exactly 3 clocks;
  - tx_done at clock 265;
  - a 16-bit sniffer sees 16'hAAAA/16'h5555 on decimated samples.
- inject_err pulses during payload bit 10 and twice during bit 20:
  - payload bits 11 and 21 inverted, with the phase of all others unchanged;
  - err_injected=2, bits_sent=64.
- ABORT accepted mid-payload:
  - next clock tx_busy=0, tx_bit_data=0, no tx_done, bits_sent frozen;
  - a subsequent START restarts from bit 1 with counters cleared.
- Back-to-back START bytes:
  - cmd_ready low the clock after each accept;
  - second START while busy is ignored and the run completes normally.
- Assert rst_n=0 asynchronously mid-tail:
  - all outputs reach reset values before the next clock edge;
  - no tx_done pulse.
